// File: rtl/root_refine.sv
// Newton-Raphson refinement of a rough sqrt(a) estimate for IEEE-754 single operands.
// Optional macro ROUND_NEAREST_EN: round-to-nearest-even at pack instead of truncation.
module root_refine #(
    parameter int unsigned ITERATIONS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exponent,
    input  logic [22:0] in_mantissa,
    input  logic        est_sign,
    input  logic [7:0]  est_exponent,
    input  logic [22:0] est_mantissa,
    input  logic        est_incorrect,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [7:0]  out_exponent,
    output logic [22:0] out_mantissa,
    output logic        out_incorrect
);
    localparam int unsigned FW         = 28;  // unsigned 2.26 fixed point
    localparam int unsigned DIV_CYCLES = 28;
    localparam int unsigned CW         = 5;
    localparam int unsigned PW         = 3;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_UPDATE, S_PACK, S_HOLD} state_t;

    state_t          r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_out_sign;
    logic [7:0]      r_out_exp;
    logic [22:0]     r_out_mant;
    logic            r_out_inc;
    logic [7:0]      r_a_exp;
    logic [22:0]     r_a_mant;
    logic            r_est_sign;
    logic [7:0]      r_est_exp;
    logic [22:0]     r_est_mant;
    logic            r_est_inc;
    logic [7:0]      r_t;
    logic [FW-1:0]   r_m;
    logic [FW-1:0]   r_y;
    logic [FW-1:0]   r_q;
    logic [FW-1:0]   r_rem;
    logic [FW-1:0]   r_dsh;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_pass;

    logic            w_e_odd;
    logic [7:0]      w_t;
    logic [FW-1:0]   w_m;
    logic [FW-1:0]   w_y_est;
    logic [FW:0]     w_trial;
    logic            w_ge;
    logic [FW-1:0]   w_diff;
    logic [FW:0]     w_sum;
    logic [22:0]     w_pack_mant;
    logic [7:0]      w_pack_exp;
    logic            w_unused;

    // Unbiased exponent is odd exactly when the biased exponent is even.
    assign w_e_odd = ~r_a_exp[0];
    assign w_t     = 8'((9'(r_a_exp) + 9'd127 - 9'(w_e_odd)) >> 1);
    assign w_m     = w_e_odd ? {1'b1, r_a_mant, 4'b0} : {2'b01, r_a_mant, 3'b0};
    assign w_y_est = (r_est_exp == w_t) ? {2'b01, r_est_mant, 3'b0} : 28'h600_0000;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    assign w_trial = {r_rem, r_dsh[FW-1]};
    assign w_ge    = (w_trial >= {1'b0, r_y});
    assign w_diff  = FW'(w_trial - {1'b0, r_y});
    assign w_sum   = {1'b0, r_y} + {1'b0, r_q};

`ifdef ROUND_NEAREST_EN
    logic        r_sticky;
    logic        w_round_up;
    logic [24:0] w_rounded;

    assign w_round_up  = r_y[2] & (r_y[3] | r_y[1] | r_y[0] | r_sticky);
    assign w_rounded   = {1'b0, r_y[26:3]} + 25'(w_round_up);
    assign w_pack_mant = w_rounded[24] ? 23'd0 : w_rounded[22:0];
    assign w_pack_exp  = w_rounded[24] ? r_t + 8'd1 : r_t;
    assign w_unused    = ^{in_sign, w_rounded[23]};

    // Anything discarded below Y in the final pass: division remainder or halving bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (r_state == S_UPDATE) begin
            r_sticky <= w_sum[0] | (r_rem != '0);
        end
    end
`else
    assign w_pack_mant = r_y[25:3];
    assign w_pack_exp  = r_t;
    assign w_unused    = ^{in_sign, w_sum[0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_sign  <= 1'b0;
            r_out_exp   <= '0;
            r_out_mant  <= '0;
            r_out_inc   <= 1'b0;
            r_a_exp     <= '0;
            r_a_mant    <= '0;
            r_est_sign  <= 1'b0;
            r_est_exp   <= '0;
            r_est_mant  <= '0;
            r_est_inc   <= 1'b0;
            r_t         <= '0;
            r_m         <= '0;
            r_y         <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_dsh       <= '0;
            r_cnt       <= '0;
            r_pass      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_exp    <= in_exponent;
                        r_a_mant   <= in_mantissa;
                        r_est_sign <= est_sign;
                        r_est_exp  <= est_exponent;
                        r_est_mant <= est_mantissa;
                        r_est_inc  <= est_incorrect;
                        r_in_ready <= 1'b0;
                        r_state    <= (est_incorrect || in_exponent == 8'd0) ? S_HOLD : S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_m     <= w_m;
                    r_t     <= w_t;
                    r_y     <= w_y_est;
                    r_rem   <= {2'b0, w_m[FW-1:2]};
                    r_dsh   <= {w_m[1:0], 26'b0};
                    r_q     <= '0;
                    r_cnt   <= '0;
                    r_pass  <= '0;
                    r_state <= S_DIV;
                end
                S_DIV: begin
                    r_rem <= w_ge ? w_diff : w_trial[FW-1:0];
                    r_q   <= {r_q[FW-2:0], w_ge};
                    r_dsh <= {r_dsh[FW-2:0], 1'b0};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(DIV_CYCLES - 1)) begin
                        r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_y    <= w_sum[FW:1];
                    r_pass <= r_pass + PW'(1);
                    if (r_pass == PW'(ITERATIONS - 1)) begin
                        r_state <= S_PACK;
                    end else begin
                        r_rem   <= {2'b0, r_m[FW-1:2]};
                        r_dsh   <= {r_m[1:0], 26'b0};
                        r_q     <= '0;
                        r_cnt   <= '0;
                        r_state <= S_DIV;
                    end
                end
                S_PACK: begin
                    r_out_sign  <= 1'b0;
                    r_out_exp   <= w_pack_exp;
                    r_out_mant  <= w_pack_mant;
                    r_out_inc   <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    // Bypass enters with out_valid low and publishes the estimate one cycle later.
                    if (!r_out_valid) begin
                        r_out_sign  <= r_est_sign;
                        r_out_exp   <= r_est_exp;
                        r_out_mant  <= r_est_mant;
                        r_out_inc   <= r_est_inc;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_sign      = r_out_sign;
    assign out_exponent  = r_out_exp;
    assign out_mantissa  = r_out_mant;
    assign out_incorrect = r_out_inc;

endmodule

// File: tb/tb_root_refine.sv
// Self-checking bench for root_refine: directed vectors, reset abort, randomized operands vs. model.
module tb_root_refine;
    localparam int ITER = 3;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exponent;
    logic [22:0] in_mantissa;
    logic        est_sign;
    logic [7:0]  est_exponent;
    logic [22:0] est_mantissa;
    logic        est_incorrect;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exponent;
    logic [22:0] out_mantissa;
    logic        out_incorrect;

    int total = 0;
    int bad   = 0;

    root_refine #(.ITERATIONS(ITER)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exponent(in_exponent), .in_mantissa(in_mantissa),
        .est_sign(est_sign), .est_exponent(est_exponent), .est_mantissa(est_mantissa),
        .est_incorrect(est_incorrect),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exponent(out_exponent), .out_mantissa(out_mantissa),
        .out_incorrect(out_incorrect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: Newton iterations Y <- (Y + m/Y)/2 on 2.26 integers, straight from the rules.
    function automatic logic [32:0] ref_sqrt(input logic [31:0] a, input logic [31:0] est,
                                             input logic est_inc);
        longint unsigned m, y, q, frac;
        int e, t;
        logic sticky;
        if (est_inc || a[30:23] == 8'd0) return {est_inc, est};
        e = int'(a[30:23]) - 127;
        m = (64'd1 << 26) | (64'(a[22:0]) << 3);
        if ((e & 1) != 0) begin
            m = m << 1;
            e = e - 1;
        end
        t = e / 2 + 127;
        if (int'(est[30:23]) == t) y = (64'd1 << 26) | (64'(est[22:0]) << 3);
        else                       y = 64'd3 << 25;
        sticky = 1'b0;
        for (int i = 0; i < ITER; i++) begin
            q = (m << 26) / y;
            sticky = (((m << 26) % y) != 0) || (((y + q) & 64'd1) != 0);
            y = (y + q) >> 1;
        end
        frac = y >> 3;
`ifdef ROUND_NEAREST_EN
        if ((y & 64'd4) != 0 && ((y & 64'd3) != 0 || sticky || (frac & 64'd1) != 0)) frac = frac + 1;
        if (frac >= (64'd1 << 24)) begin
            frac = 0;
            t = t + 1;
        end
`endif
        return {1'b0, 1'b0, 8'(t), 23'(frac)};
    endfunction

    // One transaction; stall<0 pre-asserts out_ready, else waits 'stall' cycles with out_ready low.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] est,
                          input logic est_inc, input logic [32:0] expv, input int stall);
        int lat, want_lat, w;
        want_lat = (est_inc || a[30:23] == 8'd0) ? 1 : ITER * 29 + 2;
        w = 0;
        while (in_ready !== 1'b1 && w < 10) begin
            @(posedge clk); #1; w++;
        end
        check({tag, "/in_ready_idle"}, 64'(in_ready), 64'd1);
        {in_sign, in_exponent, in_mantissa} = a;
        {est_sign, est_exponent, est_mantissa} = est;
        est_incorrect = est_inc;
        in_valid = 1'b1;
        @(posedge clk); #1;
        // Junk offered while busy must be ignored.
        {in_sign, in_exponent, in_mantissa} = $urandom();
        {est_sign, est_exponent, est_mantissa} = $urandom();
        est_incorrect = 1'($urandom());
        if (stall < 0) out_ready = 1'b1;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 400) begin
            @(posedge clk); #1; lat++;
        end
        in_valid = 1'b0;
        check({tag, "/latency"}, 64'(lat), 64'(want_lat));
        check({tag, "/result"}, 64'({out_sign, out_exponent, out_mantissa}), 64'(expv[31:0]));
        check({tag, "/incorrect"}, 64'(out_incorrect), 64'(expv[32]));
        check({tag, "/in_ready_busy"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            check({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "/hold_result"}, 64'({out_sign, out_exponent, out_mantissa}), 64'(expv[31:0]));
            check({tag, "/hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "/done_valid"}, 64'(out_valid), 64'd0);
        check({tag, "/done_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] a, est;
        logic        inc;
        logic [7:0]  ee;
        int          t;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        in_sign = 1'b0; in_exponent = '0; in_mantissa = '0;
        est_sign = 1'b0; est_exponent = '0; est_mantissa = '0; est_incorrect = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/in_ready", 64'(in_ready), 64'd1);
        check("reset/out_valid", 64'(out_valid), 64'd0);
        check("reset/out_word", 64'({out_incorrect, out_sign, out_exponent, out_mantissa}), 64'd0);
        #3 rst_n = 1'b1;

        run_op("sqrt64",    32'h4280_0000, 32'h4100_0000, 1'b0, {1'b0, 32'h4100_0000}, 0);
        run_op("sqrt50625", 32'h4745_C100, 32'h4360_0000, 1'b0, {1'b0, 32'h4361_0000}, 10);
        run_op("sqrt0p0625",32'h3D80_0000, 32'h3E90_0000, 1'b0, {1'b0, 32'h3E80_0000}, -1);
        run_op("sqrt2",     32'h4000_0000, 32'h3FC0_0000, 1'b0, {1'b0, 32'h3FB5_04F3}, 1);
        run_op("inf_bypass",32'h7F80_0000, 32'h7F80_0000, 1'b1, {1'b1, 32'h7F80_0000}, 0);
        run_op("zero_bypass",32'h0000_0000, 32'h1234_5678, 1'b0, {1'b0, 32'h1234_5678}, -1);

        // Abort mid-DIV: accept 64, reset in DIV cycle 20, then a clean 64.
        in_exponent = 8'h85; in_mantissa = '0; in_sign = 1'b0;
        est_exponent = 8'h82; est_mantissa = '0; est_sign = 1'b0; est_incorrect = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (21) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort/in_ready", 64'(in_ready), 64'd1);
        check("abort/out_valid", 64'(out_valid), 64'd0);
        check("abort/out_word", 64'({out_incorrect, out_sign, out_exponent, out_mantissa}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_abort", 32'h4280_0000, 32'h4100_0000, 1'b0, {1'b0, 32'h4100_0000}, 0);

        for (int n = 0; n < 24; n++) begin
            a = {1'($urandom()), 8'($urandom_range(1, 254)), 23'($urandom())};
            if ($urandom_range(0, 5) == 0) a[30:23] = 8'd0;
            t = int'(a[30:23]) - 127;
            if ((t & 1) != 0) t = t - 1;
            t = t / 2 + 127;
            ee = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'(t);
            est = {1'($urandom()), ee, 23'($urandom())};
            inc = ($urandom_range(0, 7) == 0);
            run_op("random", a, est, inc, ref_sqrt(a, est, inc), int'($urandom_range(0, 4)) - 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
